// File: rtl/conv_feed_ctrl.sv
// conv_feed_ctrl: operand feeder and sequencer for a 2x2 systolic array.
// Stores a 4x4 image and a 3x3 filter. On start it clears the array and
// streams 9 operand pairs, one per cycle. It then captures the four
// results of the 2x2 valid convolution.
// Ports:
//   clk, reset           - clock and async active-high reset
//   wr_en/wr_sel/wr_addr - storage write: sel 0 = image (0..15), sel 1 = filter (0..8)
//   wr_data              - word to store
//   start                - begin a pass (ignored while busy)
//   A_out_*/B_out_*      - per-lane operands to the array
//   sa_clear             - array accumulator clear
//   C_in_*               - array results
//   res_*                - captured results
//   busy, done           - pass in progress / one-cycle completion pulse
module conv_feed_ctrl #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [3:0]        wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              start,
    output logic [DATA_W-1:0] A_out_11,
    output logic [DATA_W-1:0] A_out_12,
    output logic [DATA_W-1:0] A_out_21,
    output logic [DATA_W-1:0] A_out_22,
    output logic [DATA_W-1:0] B_out_11,
    output logic [DATA_W-1:0] B_out_12,
    output logic [DATA_W-1:0] B_out_21,
    output logic [DATA_W-1:0] B_out_22,
    output logic              sa_clear,
    input  logic [DATA_W-1:0] C_in_11,
    input  logic [DATA_W-1:0] C_in_12,
    input  logic [DATA_W-1:0] C_in_21,
    input  logic [DATA_W-1:0] C_in_22,
    output logic [DATA_W-1:0] res_11,
    output logic [DATA_W-1:0] res_12,
    output logic [DATA_W-1:0] res_21,
    output logic [DATA_W-1:0] res_22,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE, CLEAR, FEED, DRAIN, DONE
    } state_t;

    state_t            state, state_nx;
    logic [3:0]        k, k_nx;
    logic [DATA_W-1:0] img [16];
    logic [DATA_W-1:0] ker [9];

    logic [DATA_W-1:0] a11_nx, a12_nx, a21_nx, a22_nx, b_nx;
    logic              clr_nx, busy_nx, done_nx;
    logic [3:0]        base;

    // Image index of the top-left lane's pixel for feed step k
    // (row k/3, column k%3 of the 4-wide image).
    function automatic logic [3:0] win_base(input logic [3:0] kk);
        logic [3:0] b;
        unique case (kk)
            4'd0:    b = 4'd0;
            4'd1:    b = 4'd1;
            4'd2:    b = 4'd2;
            4'd3:    b = 4'd4;
            4'd4:    b = 4'd5;
            4'd5:    b = 4'd6;
            4'd6:    b = 4'd8;
            4'd7:    b = 4'd9;
            4'd8:    b = 4'd10;
            default: b = 4'd0;
        endcase
        return b;
    endfunction

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            k     <= 4'd0;
        end else begin
            state <= state_nx;
            k     <= k_nx;
        end
    end

    // Next-state logic
    always_comb begin
        state_nx = state;
        k_nx     = 4'd0;
        unique case (state)
            IDLE:  if (start) state_nx = CLEAR;
            CLEAR: state_nx = FEED;
            FEED: begin
                if (k == 4'd8) begin
                    state_nx = DRAIN;
                end else begin
                    k_nx = k + 4'd1;
                end
            end
            DRAIN: state_nx = DONE;
            DONE:  state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Output logic: computed from the upcoming state so every output
    // is a plain register.
    always_comb begin
        a11_nx  = '0;
        a12_nx  = '0;
        a21_nx  = '0;
        a22_nx  = '0;
        b_nx    = '0;
        clr_nx  = (state_nx == CLEAR);
        busy_nx = (state_nx != IDLE);
        done_nx = (state_nx == DONE);
        base    = win_base(k_nx);
        if (state_nx == FEED) begin
            a11_nx = img[base];
            a12_nx = img[base + 4'd1];
            a21_nx = img[base + 4'd4];
            a22_nx = img[base + 4'd5];
            b_nx   = ker[k_nx];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            A_out_11 <= '0;
            A_out_12 <= '0;
            A_out_21 <= '0;
            A_out_22 <= '0;
            B_out_11 <= '0;
            B_out_12 <= '0;
            B_out_21 <= '0;
            B_out_22 <= '0;
            sa_clear <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            A_out_11 <= a11_nx;
            A_out_12 <= a12_nx;
            A_out_21 <= a21_nx;
            A_out_22 <= a22_nx;
            B_out_11 <= b_nx;
            B_out_12 <= b_nx;
            B_out_21 <= b_nx;
            B_out_22 <= b_nx;
            sa_clear <= clr_nx;
            busy     <= busy_nx;
            done     <= done_nx;
        end
    end

    // Storage; writable only while idle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < 16; i++) img[i] <= '0;
            for (int i = 0; i < 9; i++)  ker[i] <= '0;
        end else if (wr_en && state == IDLE) begin
            if (!wr_sel) begin
                img[wr_addr] <= wr_data;
            end else if (wr_addr <= 4'd8) begin
                ker[wr_addr] <= wr_data;
            end
        end
    end

    // The array holds its final sums while operands are zero in DRAIN.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            res_11 <= '0;
            res_12 <= '0;
            res_21 <= '0;
            res_22 <= '0;
        end else if (state == DRAIN) begin
            res_11 <= C_in_11;
            res_12 <= C_in_12;
            res_21 <= C_in_21;
            res_22 <= C_in_22;
        end
    end

endmodule
